// File: rtl/sync_fifo_v2.sv
// Single-clock pointer-based FIFO with selectable registered or first-word-fall-through
// read, programmable almost-full/almost-empty thresholds, occupancy count and sticky errors.
module sync_fifo_v2 #(
    parameter int AW    = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 1 << AW,
    parameter int FWFT  = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          err_clr,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    input  logic [AW:0]   afull_thr,
    input  logic [AW:0]   aempty_thr,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic          rempty,
    output logic          fifo_full,
    output logic          fifo_afull,
    output logic          fifo_aempty,
    output logic [AW:0]   count,
    output logic          write_ack,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] ZERO_C  = {(AW+1){1'b0}};
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] TWO_C   = (AW+1)'(2);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam bit          FWFT_C  = (FWFT != 0);

    // An error event in the same cycle as a clear keeps the flag set.
    function automatic logic sticky_next(input logic flag_q, input logic evt, input logic clr);
        sticky_next = evt | (flag_q & ~clr);
    endfunction

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          wack_q, wack_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          empty_s, full_s;
    logic          wr_acc_s, rd_acc_s;
    logic          ovf_evt_s, udf_evt_s;
    logic          load_s;
    logic [AW:0]   load_ptr_s;

    // Status flags decoded from the occupancy counter and live thresholds.
    always_comb begin
        empty_s     = (count_q == ZERO_C);
        full_s      = (count_q == DEPTH_C);
        rempty      = empty_s;
        fifo_full   = full_s;
        fifo_afull  = (count_q >= afull_thr);
        fifo_aempty = (count_q <= aempty_thr);
        count       = count_q;
        rdata       = rdata_q;
        rdata_valid = rvalid_q;
        write_ack   = wack_q;
        overflow    = ovf_q;
        underflow   = udf_q;
    end

    // Accept/reject decisions and output-register loading for the selected read mode.
    always_comb begin
        wr_acc_s   = wr & ~full_s & ~flush;
        ovf_evt_s  = wr & full_s & ~flush;
        rd_acc_s   = 1'b0;
        udf_evt_s  = 1'b0;
        load_s     = 1'b0;
        load_ptr_s = rd_ptr_q;
        rvalid_d   = 1'b0;
        if (FWFT_C) begin
            // The staged word is mem[rd_ptr]; a pop refills from the next slot if one is stored.
            rd_acc_s   = rd & rvalid_q & ~flush;
            udf_evt_s  = rd & ~rvalid_q & ~flush;
            load_s     = ~flush & ((~rvalid_q & ~empty_s) | (rd_acc_s & (count_q >= TWO_C)));
            load_ptr_s = rd_acc_s ? (rd_ptr_q + ONE_C) : rd_ptr_q;
            rvalid_d   = load_s | (rvalid_q & ~rd_acc_s & ~flush);
        end else begin
            rd_acc_s   = rd & ~empty_s & ~flush;
            udf_evt_s  = rd & empty_s & ~flush;
            load_s     = rd_acc_s;
            load_ptr_s = rd_ptr_q;
            rvalid_d   = rd_acc_s;
        end
        rdata_d = load_s ? mem_q[load_ptr_s[AW-1:0]] : rdata_q;
    end

    // Pointer, counter and flag next-state; flush overrides every request.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wack_d   = wr_acc_s;
        ovf_d    = sticky_next(ovf_q, ovf_evt_s, err_clr);
        udf_d    = sticky_next(udf_q, udf_evt_s, err_clr);
        if (flush) begin
            wr_ptr_d = ZERO_C;
            rd_ptr_d = ZERO_C;
            count_d  = ZERO_C;
            wack_d   = 1'b0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            wr_ptr_d = wr_acc_s ? (wr_ptr_q + ONE_C) : wr_ptr_q;
            rd_ptr_d = rd_acc_s ? (rd_ptr_q + ONE_C) : rd_ptr_q;
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= ZERO_C;
            rd_ptr_q <= ZERO_C;
            count_q  <= ZERO_C;
            rdata_q  <= {DW{1'b0}};
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wack_q   <= wack_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; contents are left in place by reset and flush.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: doc/sync_fifo_v2.md
Name: sync_fifo_v2

Overview:
Parametrised successor to the team's synchronous FIFO. It keeps the same single-clock, pointer-based storage and adds the following:
- selectable first-word-fall-through (FWFT) read mode;
- run-time programmable almost-full and almost-empty thresholds;
- an occupancy count output;
- sticky overflow and underflow error flags.
It sits between single-clock producers and consumers, for example DMA and MAC datapath buffering.

Parameters:
AW, 4, address width; storage depth is 2^AW words.
DW, 16, data width in bits.
DEPTH, 1<<AW, derived capacity; do not override.
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
clk  input  1  clock; all logic is on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous clear of pointers, count, output valid and error flags.
err_clr  input  1  synchronous clear of the overflow and underflow flags only.
wr  input  1  write request.
wdata  input  DW  write data.
rd  input  1  read request (standard mode) or pop (FWFT mode).
afull_thr  input  AW+1  almost-full threshold.
aempty_thr  input  AW+1  almost-empty threshold.
rdata  output  DW  read data.
rdata_valid  output  1  rdata holds a valid word.
rempty  output  1  count == 0.
fifo_full  output  1  count == DEPTH.
fifo_afull  output  1  count >= afull_thr.
fifo_aempty  output  1  count <= aempty_thr.
count  output  AW+1  words currently held, including any word staged in the FWFT output register.
write_ack  output  1  registered pulse for an accepted write.
overflow  output  1  sticky flag: a write was attempted while full.
underflow  output  1  sticky flag: a read was attempted with nothing to read.

Behaviour:
- Reset (reset_n low, asynchronous):
  - pointers = 0, count = 0, rdata = 0;
  - rdata_valid, write_ack, overflow, underflow = 0;
  - rempty = 1, fifo_full = 0;
  - fifo_aempty = 1 and fifo_afull = (afull_thr == 0), because both are combinational on count.
  - Reset asserted mid-operation discards all contents immediately.
- Pointers are AW+1 bits; the MSB is the wrap bit. count is a separate registered up/down counter that must always equal write_ptr - read_ptr modulo 2^(AW+1).
- Write accept: wr_acc = wr & ~fifo_full & ~flush.
  - Memory is written at the edge; write_ptr increments; write_ack = 1 on the following cycle only.
- Write while full (and flush low): data is dropped, overflow sets, and the pointer is unchanged.
- Standard mode (FWFT = 0):
  - rd_acc = rd & ~rempty & ~flush.
  - At the edge, rdata <= mem[read_ptr], read_ptr increments, and rdata_valid = 1 for exactly one cycle (one-cycle read latency).
  - rdata holds its value when there is no read.
- FWFT mode (FWFT = 1):
  - Whenever the output register is empty and memory holds a word, the head word is prefetched into rdata and rdata_valid = 1.
  - A word written at edge E appears with rdata_valid = 1 after edge E+1. count and rempty change after edge E.
  - A pop is rd & rdata_valid & ~flush. The register reloads on the same edge if another word is stored; otherwise rdata_valid falls.
  - Back-to-back pops therefore sustain one word per cycle.
- Underflow sets on rd with nothing to read: rempty in standard mode, ~rdata_valid in FWFT mode. Nothing else changes.
- Simultaneous accepted write and read: count is unchanged; both pointers advance.
  - At full, the write is rejected (overflow) and the read proceeds.
  - At empty, the read is rejected (underflow) and the write proceeds.
- flush has priority over wr, rd and err_clr.
  - Same-cycle requests are discarded and not flagged.
  - Memory contents are not cleared.
  - After the edge, all status outputs equal their reset values.
- err_clr clears both flags at the edge. An error event in the same cycle wins, so the flag stays set.
- Thresholds are sampled combinationally and may change at any time; the flags follow on the same cycle.
- Threshold values above DEPTH are legal: for example, fifo_afull is then never set.
- Pointer wrap past 2^AW is seamless, and full/empty remain correct across repeated wraps.

Test Plan:
- Fill/drain (AW=4, FWFT=0): write 16 words 0x0000..0x000F, then one more.
  - After the 16th write: fifo_full = 1, count = 16.
  - The 17th write sets overflow = 1.
  - Reading 16 words returns 0x0000..0x000F in order, each with a one-cycle rdata_valid pulse; then rempty = 1.
- FWFT latency (FWFT=1): write 0xA5A5 into an empty FIFO at edge E.
  - rempty falls after edge E; rdata_valid = 1 and rdata = 0xA5A5 after edge E+1.
  - Hold rd = 1 across 3 back-to-back words: one word pops per cycle with no bubble.
- Thresholds: afull_thr = 13, aempty_thr = 3.
  - Write 3 words: fifo_aempty = 1. Write a 4th: fifo_aempty = 0.
  - At count = 13, fifo_afull = 1. Change afull_thr to 14: fifo_afull falls in the same cycle.
- Simultaneous wr+rd:
  - At count = 8: count stays 8 for 20 cycles and data order is preserved across the pointer wrap.
  - At full: overflow = 1 and count = 15.
  - At empty: underflow = 1 and count = 1.
- Flush/err_clr:
  - With count = 10 and overflow = 1, flush together with wr and rd gives count = 0, rempty = 1, overflow = 0 and rdata_valid = 0, with no flags set.
  - err_clr in the same cycle as a rd on empty leaves underflow = 1.
- Reset mid-stream: assert reset_n = 0 asynchronously between edges during back-to-back writes.
  - All outputs take their reset values immediately.
  - After release, the first write and read return the new data, not stale data.
